// File: rtl/pll_ctrl_pkg.sv
// Shared types for the dynamic PLL reconfiguration controller.
// Holds the FSM state encoding, the select bundle and a width helper.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST_HOLD,
        WAIT_LOCK,
        LOCKED,
        FAIL
    } state_t;

    typedef struct packed {
        logic [5:0] idsel;
        logic [5:0] fbdsel;
        logic [5:0] odsel;
    } sel_t;

    function automatic int cnt_width(input int v);
        return ($clog2(v) < 1) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
// The synchronous reset clears both stages.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [1:0] ff_q;
    logic [1:0] ff_d;

    always_comb begin
        ff_d = {ff_q[0], d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ff_q <= '0;
        end else begin
            ff_q <= ff_d;
        end
    end

    assign q = ff_q[1];

endmodule

// File: rtl/pll_dyn_ctrl.sv
// Dynamic PLL divider controller: applies new select codes, pulses
// PLL reset, waits for lock with timeout/retry and tracks lock loss.
module pll_dyn_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int          RESET_CYCLES = 16,
    parameter int          LOCK_TIMEOUT = 100000,
    parameter int          MAX_RETRY    = 3,
    parameter logic [17:0] DEF_SEL      = 18'h0
) (
    input  logic        clkin,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [17:0] req_sel,
    input  logic        pll_lock,
    output logic        pll_reset,
    output logic [5:0]  pll_idsel,
    output logic [5:0]  pll_fbdsel,
    output logic [5:0]  pll_odsel,
    output logic        locked,
    output logic        error,
    output logic [1:0]  retries
);

    if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
        $error("pll_dyn_ctrl: RESET_CYCLES must be at least 1");
    end

    localparam int CW_R = cnt_width(RESET_CYCLES);
    localparam int CW_T = cnt_width(LOCK_TIMEOUT);
    localparam int CW   = (CW_R > CW_T) ? CW_R : CW_T;

    localparam logic [CW-1:0] RST_LAST = CW'(RESET_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(LOCK_TIMEOUT - 1);

    state_t        state_q, state_d;
    sel_t          sel_q, sel_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [1:0]    retries_q, retries_d;
    logic          locked_q, locked_d;
    logic          error_q, error_d;
    logic          pll_reset_q, pll_reset_d;
    logic          lock_s;
    logic          accept;

    sync_2ff u_lock_sync (
        .clk (clkin),
        .rst (reset),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign req_ready = !reset && (state_q == IDLE ||
                                  state_q == LOCKED ||
                                  state_q == FAIL);
    assign accept    = req_valid && req_ready;

    // Counter never wraps even if a terminal compare were missed.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        cnt_d       = cnt_q;
        retries_d   = retries_q;
        locked_d    = locked_q;
        error_d     = error_q;
        pll_reset_d = pll_reset_q;
        if (accept) begin
            state_d     = RST_HOLD;
            sel_d       = sel_t'(req_sel);
            cnt_d       = '0;
            retries_d   = '0;
            locked_d    = 1'b0;
            error_d     = 1'b0;
            pll_reset_d = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                end
                RST_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d     = WAIT_LOCK;
                        cnt_d       = '0;
                        pll_reset_d = 1'b0;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end else if (cnt_q == TO_LAST) begin
                        if (int'(retries_q) < MAX_RETRY) begin
                            state_d     = RST_HOLD;
                            retries_d   = retries_q + 2'd1;
                            cnt_d       = '0;
                            pll_reset_d = 1'b1;
                        end else begin
                            state_d = FAIL;
                            error_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                LOCKED: begin
                    // Lock loss re-waits without a new PLL reset.
                    if (!lock_s) begin
                        state_d  = WAIT_LOCK;
                        locked_d = 1'b0;
                        cnt_d    = '0;
                    end
                end
                FAIL: begin
                    error_d     = 1'b1;
                    pll_reset_d = 1'b0;
                end
                default: begin
                    state_d     = RST_HOLD;
                    cnt_d       = '0;
                    pll_reset_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q     <= RST_HOLD;
            sel_q       <= sel_t'(DEF_SEL);
            cnt_q       <= '0;
            retries_q   <= '0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            pll_reset_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            cnt_q       <= cnt_d;
            retries_q   <= retries_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            pll_reset_q <= pll_reset_d;
        end
    end

    assign pll_reset  = pll_reset_q;
    assign pll_idsel  = sel_q.idsel;
    assign pll_fbdsel = sel_q.fbdsel;
    assign pll_odsel  = sel_q.odsel;
    assign locked     = locked_q;
    assign error      = error_q;
    assign retries    = retries_q;

endmodule

// File: tb/tb_pll_dyn_ctrl.sv
// Scoreboard bench for pll_dyn_ctrl with a behavioural PLL lock model.
// Expected values are queued per cycle and checked by a monitor.
`timescale 1ns/1ps
module tb_pll_dyn_ctrl;

    localparam logic [17:0] DEF = 18'h24513;

    localparam int F_PRST   = 0;
    localparam int F_LOCKED = 1;
    localparam int F_ERR    = 2;
    localparam int F_RETRY  = 3;
    localparam int F_SEL    = 4;
    localparam int F_READY  = 5;

    typedef struct {
        int          cyc;
        int          fld;
        logic [17:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [17:0] req_sel;
    logic        pll_lock;
    logic        pll_reset;
    logic [5:0]  pll_idsel;
    logic [5:0]  pll_fbdsel;
    logic [5:0]  pll_odsel;
    logic        locked;
    logic        error;
    logic [1:0]  retries;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t m;

    bit lock_en = 1'b0;
    bit drop = 1'b0;
    int dly = 7;
    int low_cnt = 0;

    always #5 clk = ~clk;

    pll_dyn_ctrl #(
        .RESET_CYCLES (4),
        .LOCK_TIMEOUT (20),
        .MAX_RETRY    (2),
        .DEF_SEL      (DEF)
    ) dut (
        .clkin      (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_sel    (req_sel),
        .pll_lock   (pll_lock),
        .pll_reset  (pll_reset),
        .pll_idsel  (pll_idsel),
        .pll_fbdsel (pll_fbdsel),
        .pll_odsel  (pll_odsel),
        .locked     (locked),
        .error      (error),
        .retries    (retries)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // PLL model: locks dly cycles after RESET falls unless disabled.
    always @(negedge clk) begin
        #1;
        if (pll_reset) low_cnt = 0;
        else low_cnt = low_cnt + 1;
        pll_lock = lock_en && !drop && (low_cnt >= dly);
    end

    function automatic logic [17:0] act_of(input int f);
        case (f)
            F_PRST:   return {17'b0, pll_reset};
            F_LOCKED: return {17'b0, locked};
            F_ERR:    return {17'b0, error};
            F_RETRY:  return {16'b0, retries};
            F_SEL:    return {pll_idsel, pll_fbdsel, pll_odsel};
            default:  return {17'b0, req_ready};
        endcase
    endfunction

    function automatic string fname(input int f);
        case (f)
            F_PRST:   return "pll_reset";
            F_LOCKED: return "locked";
            F_ERR:    return "error";
            F_RETRY:  return "retries";
            F_SEL:    return "sel";
            default:  return "req_ready";
        endcase
    endfunction

    task automatic chk_at(input int c, input int f, input logic [17:0] v);
        exp_t e;
        int   i;
        e.cyc = c;
        e.fld = f;
        e.val = v;
        i = 0;
        while (i < sb.size() && sb[i].cyc <= c) i++;
        sb.insert(i, e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    always @(negedge clk) begin
        #2;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            m = sb.pop_front();
            checks++;
            if (m.cyc != cyc || act_of(m.fld) !== m.val) begin
                errors++;
                $display("FAIL %s @cyc %0d (now %0d): got %h want %h",
                         fname(m.fld), m.cyc, cyc, act_of(m.fld), m.val);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b, a, d, e, g, h;
        reset     = 1'b1;
        req_valid = 1'b0;
        req_sel   = 18'h0;
        repeat (3) @(negedge clk);

        // Power-up
        b = cyc;
        chk_at(b, F_PRST, 18'd1);
        chk_at(b, F_LOCKED, 18'd0);
        chk_at(b, F_ERR, 18'd0);
        chk_at(b, F_RETRY, 18'd0);
        chk_at(b, F_SEL, DEF);
        lock_en = 1'b1;
        dly     = 7;
        reset   = 1'b0;
        chk_at(b + 3, F_PRST, 18'd1);
        chk_at(b + 3, F_READY, 18'd0);
        chk_at(b + 4, F_PRST, 18'd0);
        chk_at(b + 12, F_LOCKED, 18'd0);
        chk_at(b + 13, F_LOCKED, 18'd1);
        chk_at(b + 13, F_SEL, DEF);
        chk_at(b + 13, F_READY, 18'd1);
        wait_to(b + 16);

        // Reconfiguration from LOCKED
        a         = cyc;
        dly       = 6;
        req_sel   = 18'h0A2C3;
        req_valid = 1'b1;
        chk_at(a, F_READY, 18'd1);
        chk_at(a + 1, F_SEL, 18'h0A2C3);
        chk_at(a + 1, F_LOCKED, 18'd0);
        chk_at(a + 1, F_PRST, 18'd1);
        chk_at(a + 4, F_PRST, 18'd1);
        chk_at(a + 5, F_PRST, 18'd0);
        chk_at(a + 12, F_LOCKED, 18'd0);
        chk_at(a + 13, F_LOCKED, 18'd1);
        wait_to(a + 1);
        req_valid = 1'b0;
        wait_to(a + 16);

        // Loss of lock for 5 cycles
        d    = cyc;
        drop = 1'b1;
        chk_at(d + 2, F_LOCKED, 18'd1);
        chk_at(d + 3, F_LOCKED, 18'd0);
        chk_at(d + 3, F_PRST, 18'd0);
        chk_at(d + 6, F_PRST, 18'd0);
        chk_at(d + 7, F_LOCKED, 18'd0);
        chk_at(d + 8, F_LOCKED, 18'd1);
        chk_at(d + 8, F_SEL, 18'h0A2C3);
        wait_to(d + 5);
        drop = 1'b0;
        wait_to(d + 10);

        // Request in the same cycle lock_s falls
        e    = cyc;
        drop = 1'b1;
        wait_to(e + 2);
        req_sel   = 18'h31D2E;
        req_valid = 1'b1;
        chk_at(e + 2, F_READY, 18'd1);
        chk_at(e + 3, F_PRST, 18'd1);
        chk_at(e + 3, F_SEL, 18'h31D2E);
        chk_at(e + 3, F_RETRY, 18'd0);
        chk_at(e + 3, F_LOCKED, 18'd0);
        chk_at(e + 14, F_LOCKED, 18'd0);
        chk_at(e + 15, F_LOCKED, 18'd1);
        wait_to(e + 3);
        req_valid = 1'b0;
        drop      = 1'b0;
        wait_to(e + 18);

        // Timeout, retries and FAIL
        g         = cyc;
        lock_en   = 1'b0;
        req_sel   = 18'h12345;
        req_valid = 1'b1;
        chk_at(g + 1, F_SEL, 18'h12345);
        chk_at(g + 24, F_PRST, 18'd0);
        chk_at(g + 24, F_RETRY, 18'd0);
        chk_at(g + 25, F_PRST, 18'd1);
        chk_at(g + 25, F_RETRY, 18'd1);
        chk_at(g + 48, F_PRST, 18'd0);
        chk_at(g + 48, F_RETRY, 18'd1);
        chk_at(g + 49, F_PRST, 18'd1);
        chk_at(g + 49, F_RETRY, 18'd2);
        chk_at(g + 72, F_ERR, 18'd0);
        chk_at(g + 73, F_ERR, 18'd1);
        chk_at(g + 73, F_READY, 18'd1);
        chk_at(g + 73, F_PRST, 18'd0);
        chk_at(g + 73, F_RETRY, 18'd2);
        wait_to(g + 1);
        req_valid = 1'b0;
        wait_to(g + 76);

        // Reset during WAIT_LOCK with retries=1
        h         = cyc;
        req_sel   = 18'h0ABCD;
        req_valid = 1'b1;
        chk_at(h + 1, F_ERR, 18'd0);
        chk_at(h + 1, F_RETRY, 18'd0);
        chk_at(h + 30, F_RETRY, 18'd1);
        chk_at(h + 35, F_RETRY, 18'd1);
        chk_at(h + 36, F_RETRY, 18'd0);
        chk_at(h + 36, F_SEL, DEF);
        chk_at(h + 36, F_PRST, 18'd1);
        chk_at(h + 36, F_READY, 18'd0);
        wait_to(h + 1);
        req_valid = 1'b0;
        wait_to(h + 35);
        reset     = 1'b1;
        req_sel   = 18'h3FFFF;
        req_valid = 1'b1;
        wait_to(h + 36);
        reset     = 1'b0;
        req_valid = 1'b0;
        lock_en   = 1'b1;
        dly       = 7;
        b         = cyc;
        chk_at(b + 13, F_LOCKED, 18'd1);
        chk_at(b + 13, F_SEL, DEF);
        wait_to(b + 16);

        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending checks want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pll_dyn_ctrl.md
PLL_DYN_CTRL -- requirements
Module: pll_dyn_ctrl

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 16: number of cycles pll_reset is held high per (re)configuration.
REQ-002 SHALL have parameter LOCK_TIMEOUT, default 100000: maximum number of cycles spent in WAIT_LOCK before a retry.
REQ-003 SHALL have parameter MAX_RETRY, default 3: number of retries allowed before FAIL.
REQ-004 SHALL have parameter DEF_SEL, default 18'h0: {idsel, fbdsel, odsel} codes loaded at reset.
REQ-005 SHALL have port clkin, input, 1: single clock.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port req_valid, input, 1: new divider set offered.
REQ-008 SHALL have port req_ready, output, 1: controller accepts a request.
REQ-009 SHALL have port req_sel, input, 18: {idsel, fbdsel, odsel} 6-bit dynamic select codes in PLL encoding.
REQ-010 SHALL have port pll_lock, input, 1: asynchronous LOCK from the PLL.
REQ-011 SHALL have port pll_reset, output, 1: drives PLL RESET.
REQ-012 SHALL have ports pll_idsel, pll_fbdsel and pll_odsel, output, 6 each: drive IDSEL, FBDSEL and ODSEL.
REQ-013 SHALL have port locked, output, 1: PLL locked with the current settings.
REQ-014 SHALL have port error, output, 1: retries exhausted.
REQ-015 SHALL have port retries, output, 2: retries used in the current attempt.

Function
REQ-016 SHALL implement FSM states IDLE, RST_HOLD, WAIT_LOCK, LOCKED and FAIL.
REQ-017 SHALL pass pll_lock through a 2-flop synchronizer before use; lock_s is the synchronizer output.
REQ-018 SHALL drive req_ready high only in IDLE, LOCKED and FAIL; a request is accepted when req_valid and req_ready are both high in the same cycle.
REQ-019 SHALL, on acceptance, register req_sel to the pll_*sel outputs on the next edge, clear retries and error, drop locked, and enter RST_HOLD.
REQ-020 SHALL hold pll_*sel stable at all times except at acceptance.
REQ-021 SHALL, in RST_HOLD, drive pll_reset high for exactly RESET_CYCLES cycles, then enter WAIT_LOCK with pll_reset low.
REQ-022 SHALL, in WAIT_LOCK, enter LOCKED when lock_s is high; locked rises on that transition edge, 3 cycles after pll_lock rises.
REQ-023 SHALL, in WAIT_LOCK, when lock_s stays low for LOCK_TIMEOUT cycles: if retries < MAX_RETRY, increment retries and re-enter RST_HOLD; otherwise enter FAIL.
REQ-024 SHALL, in LOCKED, on lock_s low: drop locked the next cycle and enter WAIT_LOCK with a fresh timeout, without reasserting pll_reset.
REQ-025 SHALL treat a request accepted in LOCKED in the same cycle lock_s falls as a request; the request wins.
REQ-026 SHALL, in FAIL, hold error high and pll_reset low until a request is accepted.
REQ-027 SHALL saturate the timeout and RESET_CYCLES counters and never wrap.
REQ-028 SHALL size the counters by $clog2 of their parameter.
REQ-029 SHALL leave IDLE only via a request; IDLE is reached only when RESET_CYCLES = 0 is disallowed.
REQ-030 SHALL reject RESET_CYCLES < 1 by elaboration-time assertion.

Reset
REQ-031 SHALL, on reset, load pll_*sel from DEF_SEL, clear retries, locked and error, clear the synchronizer, set pll_reset = 1 and enter RST_HOLD, so the PLL restarts automatically.
REQ-032 SHALL, on reset mid-operation in any state, take the same action as REQ-031, drop req_ready, and discard any in-flight request.

Structure
REQ-033 SHALL define the state enum and the 18-bit select bundle typedef in shared package pll_ctrl_pkg.
REQ-034 SHALL place the 2-flop synchronizer in sub-module sync_2ff, reusable elsewhere.
REQ-035 SHALL be a single always_ff FSM, one counter block and registered outputs, with no combinational path from req_valid to the pll_* outputs.

Verification
REQ-036 Bench SHALL use parameters RESET_CYCLES=4, LOCK_TIMEOUT=20 and MAX_RETRY=2 with a behavioural PLL lock model.
REQ-037 SHALL cover power-up: release reset, assert pll_lock at cycle 10 -> pll_reset high for cycles 0-3; locked=1 at cycle 13; pll_*sel = DEF_SEL.
REQ-038 SHALL cover reconfiguration: in LOCKED, present req_sel=18'h0A2C3 -> sel outputs update the next cycle; locked=0; pll_reset high for 4 cycles; lock 5 cycles later -> locked=1.
REQ-039 SHALL cover timeout/retry: hold pll_lock low -> RST_HOLD re-entered after 20 WAIT_LOCK cycles; retries 1 then 2; FAIL with error=1 after the third timeout; req_ready=1.
REQ-040 SHALL cover loss of lock: drop pll_lock for 5 cycles in LOCKED -> locked=0 3 cycles later; pll_reset stays low; locked=1 again 3 cycles after lock returns.
REQ-041 SHALL cover simultaneous events: request accepted in the same cycle lock_s falls -> RST_HOLD with new sel and retries=0.
REQ-042 SHALL cover mid-operation reset: assert reset during WAIT_LOCK with retries=1 -> next cycle retries=0, sel=DEF_SEL, pll_reset=1.
